ex_stage: RTL

//  Execute stage, sitting directly downstream of the ID/EX pipeline register.
//  It contains the ALU and ALU control, the branch-target adder and the destination-register mux.
//  It also holds an iterative 32-cycle signed multiplier with HI/LO registers, plus the EX/MEM pipeline register.

---
 rtl/ex_stage_if.sv | 36 +++
 rtl/ex_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bus of the execute stage.
// master = upstream pipeline side, slave = ex_stage.
interface ex_stage_if #(
  parameter int DW = 32
);
  // ID/EX side
  logic [1:0]    wb_ctl;
  logic [2:0]    m_ctl;
  logic [3:0]    ex_ctl;
  logic [DW-1:0] npc;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic [DW-1:0] s_extend;
  logic [4:0]    instr_2016;
  logic [4:0]    instr_1511;
  // hazard unit
  logic          stall_out;
  // EX/MEM side
  logic [1:0]    wb_ctlout;
  logic [2:0]    m_ctlout;
  logic [DW-1:0] add_result;
  logic          zero;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] rdata2out;
  logic [4:0]    muxout;

  modport master (
    output wb_ctl, m_ctl, ex_ctl, npc, rdata1, rdata2, s_extend, instr_2016, instr_1511,
    input  stall_out, wb_ctlout, m_ctlout, add_result, zero, alu_result, rdata2out, muxout
  );

  modport slave (
    input  wb_ctl, m_ctl, ex_ctl, npc, rdata1, rdata2, s_extend, instr_2016, instr_1511,
    output stall_out, wb_ctlout, m_ctlout, add_result, zero, alu_result, rdata2out, muxout
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU + ALU control, branch-target adder, destination mux,
// iterative signed multiplier with HI/LO, and the EX/MEM pipeline register.
module ex_stage #(
  parameter int DW      = 32,
  parameter int MUL_CYC = 32
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  ex_stage_if.slave ex
);
  localparam int CW = $clog2(MUL_CYC);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic            sign_q, sign_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;

  logic [1:0]    wb_q, wb_d;
  logic [2:0]    m_q, m_d;
  logic [DW-1:0] add_q, add_d;
  logic          zero_q, zero_d;
  logic [DW-1:0] alu_q, alu_d;
  logic [DW-1:0] rd2_q, rd2_d;
  logic [4:0]    mux_q, mux_d;

  logic          stall;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_out;
  logic          is_mult;
  logic [DW-1:0] rs_mag;
  logic [DW-1:0] rt_mag;
  logic [2*DW-1:0] product;

  assign alu_op  = ex.ex_ctl[2:1];
  assign funct   = ex.s_extend[5:0];
  assign op_b    = ex.ex_ctl[0] ? ex.s_extend : ex.rdata2;
  assign is_mult = (alu_op == 2'b10) && (funct == 6'h18);
  // Unsigned DW-bit magnitude still represents 2^(DW-1), so the most
  // negative operand needs no extra bit.
  assign rs_mag  = ex.rdata1[DW-1] ? (~ex.rdata1 + 1'b1) : ex.rdata1;
  assign rt_mag  = ex.rdata2[DW-1] ? (~ex.rdata2 + 1'b1) : ex.rdata2;
  assign product = sign_q ? (~acc_q + 1'b1) : acc_q;

  // ALU and ALU control decode
  always_comb begin
    alu_out = '0;
    unique case (alu_op)
      2'b00: alu_out = ex.rdata1 + op_b;
      2'b01: alu_out = ex.rdata1 - op_b;
      2'b10: begin
        case (funct)
          6'h20:   alu_out = ex.rdata1 + op_b;
          6'h22:   alu_out = ex.rdata1 - op_b;
          6'h24:   alu_out = ex.rdata1 & op_b;
          6'h25:   alu_out = ex.rdata1 | op_b;
          6'h2A:   alu_out = ($signed(ex.rdata1) < $signed(op_b)) ? DW'(1) : '0;
          6'h10:   alu_out = hi_q;
          6'h12:   alu_out = lo_q;
          default: alu_out = '0;
        endcase
      end
      default: alu_out = '0;
    endcase
  end

  // State, multiplier and EX/MEM registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      wb_q     <= '0;
      m_q      <= '0;
      add_q    <= '0;
      zero_q   <= 1'b0;
      alu_q    <= '0;
      rd2_q    <= '0;
      mux_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      wb_q     <= wb_d;
      m_q      <= m_d;
      add_q    <= add_d;
      zero_q   <= zero_d;
      alu_q    <= alu_d;
      rd2_q    <= rd2_d;
      mux_q    <= mux_d;
    end
  end

  // Next-state: flush aborts any multiply in flight
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (is_mult) state_d = MUL;
        MUL:     if (count_q == CW'(MUL_CYC - 1)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift-add multiplier datapath and HI/LO update
  always_comb begin
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (!flush) begin
      unique case (state_q)
        IDLE: begin
          if (is_mult) begin
            mcand_d  = {{DW{1'b0}}, rs_mag};
            mplier_d = rt_mag;
            sign_d   = ex.rdata1[DW-1] ^ ex.rdata2[DW-1];
            acc_d    = '0;
            count_d  = '0;
          end
        end
        MUL: begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
        end
        DONE: begin
          hi_d = product[2*DW-1:DW];
          lo_d = product[DW-1:0];
        end
        default: ;
      endcase
    end
  end

  // Outputs: stall to hazard unit and EX/MEM next values
  always_comb begin
    stall = ((state_q == IDLE) && is_mult) || (state_q == MUL);
    wb_d   = '0;
    m_d    = '0;
    add_d  = '0;
    zero_d = 1'b0;
    alu_d  = '0;
    rd2_d  = '0;
    mux_d  = '0;
    if (!flush && !stall) begin
      // The held MULT retires here without a register write.
      wb_d   = (state_q == DONE) ? 2'b00 : ex.wb_ctl;
      m_d    = ex.m_ctl;
      add_d  = ex.npc + (ex.s_extend << 2);
      alu_d  = alu_out;
      zero_d = (alu_out == '0);
      rd2_d  = ex.rdata2;
      mux_d  = ex.ex_ctl[3] ? ex.instr_1511 : ex.instr_2016;
    end
  end

  assign ex.stall_out  = stall;
  assign ex.wb_ctlout  = wb_q;
  assign ex.m_ctlout   = m_q;
  assign ex.add_result = add_q;
  assign ex.zero       = zero_q;
  assign ex.alu_result = alu_q;
  assign ex.rdata2out  = rd2_q;
  assign ex.muxout     = mux_q;
endmodule
